// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: operation sequencer for the calculator datapath.
//
// Two raw pushbuttons are synchronised, debounced and edge-detected. The
// resulting press pulses drive a four-state cycle:
//   ENTER_A -> (next) latch A -> ENTER_B -> (next) latch B/op -> EXEC
//   -> ALU_LAT cycles -> capture result/ovf -> SHOW -> (next) -> ENTER_A
// A clr press in any state returns to ENTER_A and zeroes all operands,
// the result and the error flag.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   key_next, key_clr raw active-high pushbuttons (asynchronous to clk)
//   sw_val, sw_func   operand / op switches
//   alu_a/b/func      registered operands and op to the ALU
//   alu_result/ovf    combinational ALU result and overflow flag
//   result, err       captured ALU result and overflow (err is sticky)
//   disp_sel          1 = display A/B, 0 = display result
//   disp_blank        blank all digits (error blink in SHOW)
//   state             current state code for LEDs
module calc_seq_ctrl #(
    parameter int WIDTH        = 6,
    parameter int DEB_CYCLES   = 50000,
    parameter int ALU_LAT      = 2,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_next,
    input  logic                 key_clr,
    input  logic [WIDTH-1:0]     sw_val,
    input  logic [1:0]           sw_func,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_func,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_ovf,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 disp_sel,
    output logic                 disp_blank,
    output logic [1:0]           state
);

    localparam int DW = (DEB_CYCLES   > 1) ? $clog2(DEB_CYCLES)   : 1;
    localparam int EW = (ALU_LAT      > 1) ? $clog2(ALU_LAT)      : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        EXEC    = 2'b10,
        SHOW    = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // Key path: index 0 = next, index 1 = clr
    // ------------------------------------------------------------------
    logic [1:0]         key_raw;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_prev_q;
    logic [1:0][DW-1:0] deb_cnt_q;
    logic [1:0]         press;

    assign key_raw = {key_clr, key_next};
    assign press   = deb_q & ~deb_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int k = 0; k < 2; k++) begin
                // Any cycle where the synced value agrees with the level
                // restarts the stability count.
                if (sync2_q[k] == deb_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
                    deb_q[k]     <= sync2_q[k];
                    deb_cnt_q[k] <= '0;
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    logic next_pulse, clr_pulse;
    assign next_pulse = press[0];
    assign clr_pulse  = press[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [WIDTH-1:0]     alu_a_q, alu_b_q;
    logic [1:0]           alu_func_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;
    logic                 blank_q;
    logic [EW-1:0]        exec_cnt_q;
    logic [BW-1:0]        blink_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            blank_q     <= 1'b0;
            exec_cnt_q  <= '0;
            blink_cnt_q <= '0;
        end else if (clr_pulse) begin
            // clr outranks next and aborts EXEC without a capture
            state_q     <= ENTER_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            blank_q     <= 1'b0;
            exec_cnt_q  <= '0;
            blink_cnt_q <= '0;
        end else begin
            // Blink is idle unless SHOW keeps running with err set below;
            // this also clears disp_blank on the edge that leaves SHOW.
            blank_q     <= 1'b0;
            blink_cnt_q <= '0;
            case (state_q)
                ENTER_A: begin
                    if (next_pulse) begin
                        alu_a_q <= sw_val;
                        state_q <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (next_pulse) begin
                        alu_b_q    <= sw_val;
                        alu_func_q <= sw_func;
                        exec_cnt_q <= '0;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    // next pulses are dropped here, not queued
                    if (exec_cnt_q == EW'(ALU_LAT - 1)) begin
                        result_q <= alu_result;
                        err_q    <= alu_ovf;
                        state_q  <= SHOW;
                    end else begin
                        exec_cnt_q <= exec_cnt_q + EW'(1);
                    end
                end
                SHOW: begin
                    if (next_pulse) begin
                        state_q <= ENTER_A;
                    end else if (err_q) begin
                        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                            blink_cnt_q <= '0;
                            blank_q     <= ~blank_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BW'(1);
                            blank_q     <= blank_q;
                        end
                    end
                end
                default: state_q <= ENTER_A;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_func   = alu_func_q;
    assign result     = result_q;
    assign err        = err_q;
    assign disp_blank = blank_q;
    assign state      = state_q;
    // A/B are on display while entering, the result from EXEC onward
    assign disp_sel   = ~state_q[1];

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;

    localparam int W     = 6;
    localparam int DEB   = 4;
    localparam int LAT   = 2;
    localparam int BLINK = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           key_next, key_clr;
    logic [W-1:0]   sw_val;
    logic [1:0]     sw_func;
    logic [W-1:0]   alu_a, alu_b;
    logic [1:0]     alu_func;
    logic [2*W-1:0] alu_result;
    logic           alu_ovf;
    logic [2*W-1:0] result;
    logic           err, disp_sel, disp_blank;
    logic [1:0]     state;
    logic           ovf_force;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    calc_seq_ctrl #(
        .WIDTH(W), .DEB_CYCLES(DEB), .ALU_LAT(LAT), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .key_next(key_next), .key_clr(key_clr),
        .sw_val(sw_val), .sw_func(sw_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_result(alu_result), .alu_ovf(alu_ovf),
        .result(result), .err(err), .disp_sel(disp_sel),
        .disp_blank(disp_blank), .state(state)
    );

    always #5 clk = ~clk;

    // Simple signed ALU: 0 add, 1 sub, 2 mul, 3 and
    function automatic logic [2*W-1:0] alu_f(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0] f);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        case (f)
            2'd0:    return sa + sb;
            2'd1:    return sa - sb;
            2'd2:    return sa * sb;
            default: return sa & sb;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_a, alu_b, alu_func);
    assign alu_ovf = ovf_force;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit             rd1[2], rd2[2], lvl[2], prv[2], pr[2];
    int             run[2];
    bit             s;
    logic [1:0]     m_st, st0;
    logic [W-1:0]   m_a, m_b;
    logic [1:0]     m_f;
    logic [2*W-1:0] m_res;
    bit             m_err, m_blank;
    int             m_ecnt, m_bcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rd1[k] = 0; rd2[k] = 0; lvl[k] = 0; prv[k] = 0; run[k] = 0;
            end
            m_st = 0; m_a = 0; m_b = 0; m_f = 0; m_res = 0;
            m_err = 0; m_blank = 0; m_ecnt = 0; m_bcnt = 0;
        end else begin
            // Press = level went 0->1 on the previous edge; level changes
            // after DEB consecutive disagreeing samples of the 2-cycle-late key.
            for (int k = 0; k < 2; k++) begin
                pr[k]  = lvl[k] && !prv[k];
                prv[k] = lvl[k];
                s      = rd2[k];
                if (s != lvl[k]) begin
                    run[k]++;
                    if (run[k] == DEB) begin
                        lvl[k] = s;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
                rd2[k] = rd1[k];
                rd1[k] = (k == 0) ? key_next : key_clr;
            end
            st0 = m_st;
            if (pr[1]) begin
                m_st = 0; m_a = 0; m_b = 0; m_f = 0; m_res = 0;
                m_err = 0; m_blank = 0; m_bcnt = 0; m_ecnt = 0;
            end else begin
                case (m_st)
                    2'd0: if (pr[0]) begin m_a = sw_val; m_st = 1; end
                    2'd1: if (pr[0]) begin
                        m_b = sw_val; m_f = sw_func; m_ecnt = 0; m_st = 2;
                    end
                    2'd2: begin
                        m_ecnt++;
                        if (m_ecnt == LAT) begin
                            m_res = alu_f(m_a, m_b, m_f);
                            m_err = alu_ovf;
                            m_st  = 3;
                        end
                    end
                    default: if (pr[0]) m_st = 0;
                endcase
                if (st0 == 3 && m_st == 3 && m_err) begin
                    m_bcnt++;
                    if (m_bcnt == BLINK) begin
                        m_bcnt  = 0;
                        m_blank = !m_blank;
                    end
                end else begin
                    m_bcnt  = 0;
                    m_blank = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({state, alu_a, alu_b, alu_func, result, err, disp_sel, disp_blank} !==
                {m_st, m_a, m_b, m_f, m_res, m_err, (m_st < 2), m_blank}) begin
                failures++;
                $display("FAIL model t=%0t dut st=%0d a=%0h b=%0h f=%0d res=%0h err=%0b sel=%0b blk=%0b exp st=%0d a=%0h b=%0h f=%0d res=%0h err=%0b sel=%0b blk=%0b",
                         $time, state, alu_a, alu_b, alu_func, result, err, disp_sel, disp_blank,
                         m_st, m_a, m_b, m_f, m_res, m_err, (m_st < 2), m_blank);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold 4 cycles (press lands 6 edges later), then release long enough
    // for the debounced level to drop again.
    task automatic press_next();
        key_next = 1'b1;
        cyc(4);
        key_next = 1'b0;
        cyc(8);
    endtask

    initial begin
        rst = 1'b1; key_next = 1'b0; key_clr = 1'b0;
        sw_val = '0; sw_func = '0; ovf_force = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_sel", disp_sel, 1);
        chk("rst_blank", disp_blank, 0);

        // Bounce 1,0 then hold: exactly one press, 6 edges after hold start
        sw_val = 6'd5;
        key_next = 1'b1; cyc(1);
        key_next = 1'b0; cyc(1);
        key_next = 1'b1;
        cyc(6);
        chk("deb_early", state, 0);
        cyc(1);
        chk("deb_press", state, 1);
        chk("latch_a", alu_a, 5);
        cyc(20);
        chk("hold_no_repeat", state, 1);
        key_next = 1'b0;
        cyc(8);

        // B = -3, op = mul -> -15
        sw_val = 6'b111101; sw_func = 2'd2;
        key_next = 1'b1; cyc(4);
        key_next = 1'b0; cyc(2);
        chk("b_wait", state, 1);
        cyc(1);
        chk("exec_enter", state, 2);
        chk("exec_sel", disp_sel, 0);
        // key activity during EXEC must not affect the sequence
        key_next = 1'b1; cyc(1);
        chk("exec_1", state, 2);
        key_next = 1'b0; cyc(1);
        chk("show_state", state, 3);
        chk("mul_result", result, 12'hFF1);
        chk("mul_err", err, 0);
        chk("latch_b", alu_b, 6'h3D);
        chk("latch_func", alu_func, 2);
        cyc(10);
        chk("show_stays", state, 3);
        chk("show_noblank", disp_blank, 0);
        press_next();
        chk("back_a", state, 0);
        chk("back_sel", disp_sel, 1);
        chk("a_held", alu_a, 5);
        chk("res_held", result, 12'hFF1);

        // Overflow capture and blink: 7 + 2 with ovf set
        ovf_force = 1'b1;
        sw_val = 6'd7; press_next();
        sw_val = 6'd2; sw_func = 2'd0;
        key_next = 1'b1; cyc(4);
        key_next = 1'b0; cyc(4);
        chk("ovf_exec", state, 2);
        cyc(1);
        chk("ovf_show", state, 3);
        chk("ovf_err", err, 1);
        chk("add_result", result, 12'h009);
        chk("blank_0", disp_blank, 0);
        cyc(7); chk("blank_7", disp_blank, 0);
        cyc(1); chk("blank_8", disp_blank, 1);
        cyc(7); chk("blank_15", disp_blank, 1);
        cyc(1); chk("blank_16", disp_blank, 0);
        cyc(8); chk("blank_24", disp_blank, 1);
        key_next = 1'b1; cyc(4);
        key_next = 1'b0; cyc(3);
        chk("leave_state", state, 0);
        chk("leave_blank", disp_blank, 0);
        chk("leave_err", err, 1);
        cyc(5);
        ovf_force = 1'b0;

        // clr and next together in ENTER_B: clr wins
        sw_val = 6'd9; press_next();
        chk("enter_b", state, 1);
        chk("a_nine", alu_a, 9);
        key_next = 1'b1; key_clr = 1'b1; cyc(4);
        key_next = 1'b0; key_clr = 1'b0; cyc(8);
        chk("clr_state", state, 0);
        chk("clr_a", alu_a, 0);
        chk("clr_b", alu_b, 0);
        chk("clr_err", err, 0);
        chk("clr_result", result, 0);

        // Reset in the middle of EXEC
        ovf_force = 1'b1;
        sw_val = 6'd3; press_next();
        sw_val = 6'd4; sw_func = 2'd0; press_next();
        chk("pre_rst_res", result, 7);
        press_next();
        sw_val = 6'd1; press_next();
        key_next = 1'b1; cyc(4);
        key_next = 1'b0; cyc(3);
        chk("pre_rst_exec", state, 2);
        chk("pre_rst_err", err, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_sel", disp_sel, 1);
        chk("mid_rst_blank", disp_blank, 0);
        cyc(2);
        rst = 1'b0;
        ovf_force = 1'b0;
        cyc(3);
        chk("post_rst_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
